// File: rtl/sideband_commit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sideband_commit_ctrl                                       |
// | Description : Write-side sequencer for the 512x20 sideband FIFO. Tracks  |
// |               ingress frames, builds the {src, mask, len} descriptor,    |
// |               commits accepted frames and rewinds the frame buffer on    |
// |               filter drops and SOP aborts.                               |
// | Options     : SIDEBAND_STATS_EN adds commit/drop/abort counters.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sideband_commit_ctrl #(
  parameter int LEN_W   = 12,
  parameter int N_PORTS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [$clog2(N_PORTS)-1:0] in_src,
  input  logic                       flt_dest_valid,
  input  logic [N_PORTS-1:0]         flt_dest_mask,
  input  logic                       flt_drop,
  output logic [19:0]                sb_wdata,
  output logic                       sb_wen,
  input  logic                       sb_full,
  output logic                       fb_rst_wptr,
`ifdef SIDEBAND_STATS_EN
  output logic                       busy,
  output logic [15:0]                stat_commit,
  output logic [15:0]                stat_drop,
  output logic [15:0]                stat_abort
`else
  output logic                       busy
`endif
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_hdr     = 3'd1;
  localparam logic [2:0] c_st_scan    = 3'd2;
  localparam logic [2:0] c_st_wait    = 3'd3;
  localparam logic [2:0] c_st_commit  = 3'd4;
  localparam logic [2:0] c_st_discard = 3'd5;

  // The descriptor length field is 12 bits, so the count never goes past 4095.
  localparam logic [LEN_W-1:0] c_len_max = (LEN_W > 12) ? LEN_W'(12'hFFF) : {LEN_W{1'b1}};

  logic [2:0]                 r_state;
  logic [2:0]                 w_next;
  logic [$clog2(N_PORTS)-1:0] r_src;
  logic [N_PORTS-1:0]         r_mask;
  logic [LEN_W-1:0]           r_len;
  logic                       r_len_sat;
  logic                       r_fb_rst;
  logic [11:0]                w_len_fld;

  logic w_beat;
  logic w_start;
  logic w_len_inc;
  logic w_mask_ld;
  logic w_rw_drop;
  logic w_rw_abort;

  assign w_beat = in_valid & in_ready;

  generate
    if (LEN_W >= 12) begin : g_len_trunc
      assign w_len_fld = r_len[11:0];
    end else begin : g_len_pad
      assign w_len_fld = {{(12-LEN_W){1'b0}}, r_len};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the per-cycle datapath events it implies.
  // An SOP abort outranks a same-cycle filter drop: the old frame is rewound
  // either way and the new frame must start tracking on this beat.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_len_inc  = 1'b0;
    w_mask_ld  = 1'b0;
    w_rw_drop  = 1'b0;
    w_rw_abort = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_beat && in_sop) begin
          w_start = 1'b1;
          w_next  = in_eop ? c_st_wait : c_st_hdr;
        end
      end
      c_st_hdr, c_st_scan: begin
        if (w_beat && in_sop) begin
          w_rw_abort = 1'b1;
          w_start    = 1'b1;
          w_next     = in_eop ? c_st_wait : c_st_hdr;
        end else if (flt_drop) begin
          if (w_beat && in_eop) begin
            w_rw_drop = 1'b1;
            w_next    = c_st_idle;
          end else begin
            w_next = c_st_discard;
          end
        end else begin
          w_len_inc = w_beat;
          if ((r_state == c_st_hdr) && flt_dest_valid) begin
            // Verdict and EOP together leave nothing to wait for.
            w_mask_ld = 1'b1;
            w_next    = (w_beat && in_eop) ? c_st_commit : c_st_scan;
          end else if (w_beat && in_eop) begin
            w_next = (r_state == c_st_hdr) ? c_st_wait : c_st_commit;
          end
        end
      end
      c_st_wait: begin
        if (flt_drop) begin
          w_rw_drop = 1'b1;
          w_next    = c_st_idle;
        end else if (flt_dest_valid) begin
          w_mask_ld = 1'b1;
          w_next    = c_st_commit;
        end
      end
      c_st_commit: begin
        if (!sb_full) begin
          w_next = c_st_idle;
        end
      end
      c_st_discard: begin
        if (w_beat && in_sop) begin
          w_rw_abort = 1'b1;
          w_start    = 1'b1;
          w_next     = in_eop ? c_st_wait : c_st_hdr;
        end else if (w_beat && in_eop) begin
          w_rw_drop = 1'b1;
          w_next    = c_st_idle;
        end
      end
      default: begin
        w_next = c_st_idle;
      end
    endcase
  end

  // State-decoded outputs. The write strobe uses the live full flag so the
  // write lands in the first non-full COMMIT cycle.
  always_comb begin
    in_ready = (r_state != c_st_wait) && (r_state != c_st_commit);
    busy     = (r_state != c_st_idle);
    sb_wen   = (r_state == c_st_commit) && !sb_full;
  end

  // Descriptor fields, saturating length counter and the rewind pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src     <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_len_sat <= 1'b0;
      r_fb_rst  <= 1'b0;
    end else begin
      r_fb_rst <= w_rw_drop | w_rw_abort;
      if (w_start) begin
        r_src     <= in_src;
        r_len     <= LEN_W'(1);
        r_len_sat <= 1'b0;
      end else if (w_len_inc) begin
        if (r_len == c_len_max) begin
          r_len_sat <= 1'b1;
        end else begin
          r_len <= r_len + LEN_W'(1);
        end
      end
      if (w_mask_ld) begin
        r_mask <= flt_dest_mask;
      end
    end
  end

  assign sb_wdata    = {r_src, r_mask, 1'b0, r_len_sat, w_len_fld};
  assign fb_rst_wptr = r_fb_rst;

`ifdef SIDEBAND_STATS_EN
  // Wrapping event counters for commits, filter-drop rewinds and SOP aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_commit <= '0;
      stat_drop   <= '0;
      stat_abort  <= '0;
    end else begin
      if (sb_wen)     stat_commit <= stat_commit + 16'd1;
      if (w_rw_drop)  stat_drop   <= stat_drop + 16'd1;
      if (w_rw_abort) stat_abort  <= stat_abort + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
